// File: rtl/wb_host_bridge.sv
// Single-outstanding Wishbone master: turns host request/response handshakes into
// classic-pipelined Wishbone cycles with retry, error and timeout handling.
module wb_host_bridge #(
    parameter int ADDR_WIDTH = 3,
    parameter int TIMEOUT    = 255,
    parameter int MAX_RETRY  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  host_req_i,
    input  logic                  host_we_i,
    input  logic [ADDR_WIDTH-1:0] host_adr_i,
    input  logic [3:0]            host_sel_i,
    input  logic [31:0]           host_dat_i,
    output logic                  host_ready_o,
    output logic                  host_ack_o,
    output logic                  host_err_o,
    output logic [1:0]            host_status_o,
    output logic [31:0]           host_dat_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_dat_o,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i,
    input  logic                  wb_stall_i,
    input  logic [31:0]           wb_dat_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_GAP,
        S_RESP
    } state_t;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_BERR = 2'b01;
    localparam logic [1:0] ST_TMO  = 2'b10;
    localparam logic [1:0] ST_RTY  = 2'b11;

    localparam logic [15:0]           TMO_LAST  = 16'(TIMEOUT);
    localparam logic [3:0]            RETRY_MAX = 4'(MAX_RETRY);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~(ADDR_WIDTH'(3));

    state_t                r_state;
    logic                  r_ready;
    logic                  r_ack_p;
    logic                  r_err_p;
    logic [1:0]            r_status;
    logic [31:0]           r_rdat;
    logic                  r_cyc;
    logic                  r_stb;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [3:0]            r_sel;
    logic [31:0]           r_wdat;
    logic [3:0]            r_retry;
    logic [15:0]           r_tmo;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_ack_p  <= 1'b0;
            r_err_p  <= 1'b0;
            r_status <= ST_OK;
            r_rdat   <= '0;
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_sel    <= '0;
            r_wdat   <= '0;
            r_retry  <= '0;
            r_tmo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (host_req_i) begin
                        r_we    <= host_we_i;
                        r_adr   <= host_adr_i & WORD_MASK;
                        r_sel   <= host_sel_i;
                        r_wdat  <= host_dat_i;
                        r_retry <= '0;
                        r_tmo   <= 16'd1;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= S_BUS;
                    end
                end

                S_BUS: begin
                    // Terminations are honoured even while the strobe is still stalled;
                    // err outranks ack, ack outranks rty, any of them outranks timeout.
                    if (wb_err_i) begin
                        r_status <= ST_BERR;
                        r_err_p  <= 1'b1;
                        r_cyc    <= 1'b0;
                        r_stb    <= 1'b0;
                        r_state  <= S_RESP;
                    end else if (wb_ack_i) begin
                        if (!r_we) begin
                            r_rdat <= wb_dat_i;
                        end
                        r_status <= ST_OK;
                        r_ack_p  <= 1'b1;
                        r_cyc    <= 1'b0;
                        r_stb    <= 1'b0;
                        r_state  <= S_RESP;
                    end else if (wb_rty_i) begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        if (r_retry < RETRY_MAX) begin
                            r_retry <= r_retry + 4'd1;
                            r_state <= S_GAP;
                        end else begin
                            r_status <= ST_RTY;
                            r_err_p  <= 1'b1;
                            r_state  <= S_RESP;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_status <= ST_TMO;
                        r_err_p  <= 1'b1;
                        r_cyc    <= 1'b0;
                        r_stb    <= 1'b0;
                        r_state  <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                        if (!wb_stall_i) begin
                            r_stb <= 1'b0;
                        end
                    end
                end

                S_GAP: begin
                    r_tmo   <= 16'd1;
                    r_cyc   <= 1'b1;
                    r_stb   <= 1'b1;
                    r_state <= S_BUS;
                end

                S_RESP: begin
                    r_ack_p <= 1'b0;
                    r_err_p <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                    r_ack_p <= 1'b0;
                    r_err_p <= 1'b0;
                end
            endcase
        end
    end

    assign host_ready_o  = r_ready;
    assign host_ack_o    = r_ack_p;
    assign host_err_o    = r_err_p;
    assign host_status_o = r_status;
    assign host_dat_o    = r_rdat;
    assign wb_cyc_o      = r_cyc;
    assign wb_stb_o      = r_stb;
    assign wb_we_o       = r_we;
    assign wb_adr_o      = r_adr;
    assign wb_sel_o      = r_sel;
    assign wb_dat_o      = r_wdat;

endmodule

// File: tb/tb_wb_host_bridge.sv
// Directed table-driven bench for wb_host_bridge with a configurable Wishbone slave model.
module tb_wb_host_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_req;
    logic        host_we;
    logic [2:0]  host_adr;
    logic [3:0]  host_sel;
    logic [31:0] host_dat;
    logic        host_ready;
    logic        host_ack;
    logic        host_err;
    logic [1:0]  host_status;
    logic [31:0] host_rdat;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [2:0]  wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_wdat;
    logic        wb_ack   = 1'b0;
    logic        wb_err   = 1'b0;
    logic        wb_rty   = 1'b0;
    logic        wb_stall = 1'b0;
    logic [31:0] wb_rdat  = '0;

    always #5 clk = ~clk;

    wb_host_bridge #(
        .ADDR_WIDTH(3),
        .TIMEOUT(4),
        .MAX_RETRY(3)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .host_req_i   (host_req),
        .host_we_i    (host_we),
        .host_adr_i   (host_adr),
        .host_sel_i   (host_sel),
        .host_dat_i   (host_dat),
        .host_ready_o (host_ready),
        .host_ack_o   (host_ack),
        .host_err_o   (host_err),
        .host_status_o(host_status),
        .host_dat_o   (host_rdat),
        .wb_cyc_o     (wb_cyc),
        .wb_stb_o     (wb_stb),
        .wb_we_o      (wb_we),
        .wb_adr_o     (wb_adr),
        .wb_sel_o     (wb_sel),
        .wb_dat_o     (wb_wdat),
        .wb_ack_i     (wb_ack),
        .wb_err_i     (wb_err),
        .wb_rty_i     (wb_rty),
        .wb_stall_i   (wb_stall),
        .wb_dat_i     (wb_rdat)
    );

    // Slave behaviour: stall for attempt cycles 1..cfg_stall, respond in cycle cfg_resp
    // (0 = never); the first cfg_rty attempts answer rty, later ones answer cfg_fin
    // (0 ack, 1 err, 2 err+ack).
    int          cfg_stall = 0;
    int          cfg_resp  = 0;
    int          cfg_rty   = 0;
    int          cfg_fin   = 0;
    logic [31:0] cfg_rdat  = '0;
    int          acyc = 0;
    int          att  = 0;

    always @(negedge clk) begin
        if (wb_cyc) begin
            acyc = acyc + 1;
        end else begin
            if (acyc != 0) att = att + 1;
            acyc = 0;
        end
        if (host_ready) att = 0;
        wb_stall = wb_cyc && (acyc <= cfg_stall);
        wb_rdat  = cfg_rdat;
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        wb_rty   = 1'b0;
        if (wb_cyc && cfg_resp != 0 && acyc == cfg_resp) begin
            if (att < cfg_rty) begin
                wb_rty = 1'b1;
            end else begin
                wb_ack = (cfg_fin == 0) || (cfg_fin == 2);
                wb_err = (cfg_fin == 1) || (cfg_fin == 2);
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        int          stall_n;
        int          resp_cyc;
        int          rty_n;
        int          fin;
        logic [31:0] rdat;
        logic [1:0]  st;
        logic [31:0] dat;
        int          done;
        int          cyc_hi;
        int          stb_hi;
        int          gaps;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v);
        int          done_k;
        int          pulses;
        int          cyc_hi;
        int          stb_hi;
        int          gaps;
        int          stab_err;
        logic        got_ack;
        logic        got_err;
        logic [1:0]  got_st;
        logic [31:0] got_dat;
        logic [2:0]  exp_adr;
        bit          finished;
        done_k = -1; pulses = 0; cyc_hi = 0; stb_hi = 0; gaps = 0; stab_err = 0;
        got_ack = 1'b0; got_err = 1'b0; got_st = '0; got_dat = '0; finished = 0;
        exp_adr = v.adr & 3'b100;
        @(negedge clk);
        cfg_stall = v.stall_n; cfg_resp = v.resp_cyc; cfg_rty = v.rty_n;
        cfg_fin = v.fin; cfg_rdat = v.rdat;
        host_we = v.we; host_adr = v.adr; host_sel = v.sel; host_dat = v.wdat;
        host_req = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) host_req = 1'b0;
            if (wb_we !== v.we || wb_adr !== exp_adr || wb_sel !== v.sel || wb_wdat !== v.wdat)
                stab_err = stab_err + 1;
            if (wb_cyc) cyc_hi = cyc_hi + 1;
            if (wb_stb) stb_hi = stb_hi + 1;
            if (!wb_cyc && !host_ready && !host_ack && !host_err) gaps = gaps + 1;
            if (host_ack || host_err) begin
                pulses = pulses + 1;
                if (done_k < 0) begin
                    done_k  = k;
                    got_ack = host_ack;
                    got_err = host_err;
                    got_st  = host_status;
                    got_dat = host_rdat;
                end
            end
            if (host_ready && pulses > 0) begin
                finished = 1;
                break;
            end
        end
        chk({v.name, " finished"}, 32'(finished), 32'd1);
        chk({v.name, " done_cycle"}, done_k, v.done);
        chk({v.name, " pulses"}, pulses, 1);
        chk({v.name, " ack"}, 32'(got_ack), 32'(v.st == 2'b00));
        chk({v.name, " err"}, 32'(got_err), 32'(v.st != 2'b00));
        chk({v.name, " status"}, 32'(got_st), 32'(v.st));
        chk({v.name, " rdata"}, got_dat, v.dat);
        chk({v.name, " status_hold"}, 32'(host_status), 32'(v.st));
        chk({v.name, " rdata_hold"}, host_rdat, v.dat);
        chk({v.name, " cyc_cycles"}, cyc_hi, v.cyc_hi);
        chk({v.name, " stb_cycles"}, stb_hi, v.stb_hi);
        chk({v.name, " gap_cycles"}, gaps, v.gaps);
        chk({v.name, " bus_stable"}, stab_err, 0);
    endtask

    initial begin
        int pulses;
        int cyc_hi;

        vecs[0] = '{"rb_read",    1'b0, 3'b101, 4'hF, 32'h0,        2, 2, 0, 0, 32'hCAFE0001,
                    2'b00, 32'hCAFE0001, 3, 2, 2, 0};
        vecs[1] = '{"stall_write", 1'b1, 3'b010, 4'b0011, 32'h12345678, 3, 4, 0, 0, 32'hFFFFFFFF,
                    2'b00, 32'hCAFE0001, 5, 4, 4, 0};
        vecs[2] = '{"err_and_ack", 1'b0, 3'b000, 4'hF, 32'h0,        0, 1, 0, 2, 32'hDEADBEEF,
                    2'b01, 32'hCAFE0001, 2, 1, 1, 0};
        vecs[3] = '{"rty_twice",   1'b0, 3'b110, 4'hF, 32'h0,        0, 1, 2, 0, 32'h0BADF00D,
                    2'b00, 32'h0BADF00D, 6, 3, 3, 2};
        vecs[4] = '{"rty_exhaust", 1'b0, 3'b001, 4'h1, 32'h0,        0, 1, 4, 0, 32'h11111111,
                    2'b11, 32'h0BADF00D, 8, 4, 4, 3};
        vecs[5] = '{"timeout",     1'b0, 3'b100, 4'hF, 32'h0,        0, 0, 0, 0, 32'h22222222,
                    2'b10, 32'h0BADF00D, 5, 4, 1, 0};
        vecs[6] = '{"ack_at_last", 1'b0, 3'b111, 4'hF, 32'h0,        0, 4, 0, 0, 32'h55AA55AA,
                    2'b00, 32'h55AA55AA, 5, 4, 1, 0};
        vecs[7] = '{"write_err",   1'b1, 3'b011, 4'hF, 32'hA5A5A5A5, 1, 2, 0, 1, 32'h33333333,
                    2'b01, 32'h55AA55AA, 3, 2, 2, 0};
        vecs[8] = '{"stall_tmo",   1'b1, 3'b110, 4'hC, 32'h0F0F0F0F, 9, 0, 0, 0, 32'h44444444,
                    2'b10, 32'h55AA55AA, 5, 4, 4, 0};
        vecs[9] = '{"zw_write",    1'b1, 3'b001, 4'h8, 32'h89ABCDEF, 0, 1, 0, 0, 32'h66666666,
                    2'b00, 32'h55AA55AA, 2, 1, 1, 0};

        rst_n = 1'b0; host_req = 1'b0; host_we = 1'b0; host_adr = '0; host_sel = '0; host_dat = '0;
        repeat (2) @(negedge clk);
        chk("reset ready", 32'(host_ready), 32'd1);
        chk("reset ack", 32'(host_ack), 32'd0);
        chk("reset err", 32'(host_err), 32'd0);
        chk("reset status", 32'(host_status), 32'd0);
        chk("reset rdata", host_rdat, 32'd0);
        chk("reset cyc", 32'(wb_cyc), 32'd0);
        chk("reset stb", 32'(wb_stb), 32'd0);
        chk("reset we", 32'(wb_we), 32'd0);
        chk("reset adr", 32'(wb_adr), 32'd0);
        chk("reset sel", 32'(wb_sel), 32'd0);
        chk("reset wdat", wb_wdat, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Request held high across a zero-wait slave: accepts at cycles 0, 3 and 6 only.
        @(negedge clk);
        cfg_stall = 0; cfg_resp = 1; cfg_rty = 0; cfg_fin = 0; cfg_rdat = 32'h00000077;
        host_we = 1'b0; host_adr = 3'b100; host_sel = 4'hF; host_dat = '0;
        host_req = 1'b1;
        pulses = 0; cyc_hi = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (host_ack || host_err) pulses = pulses + 1;
            if (wb_cyc) cyc_hi = cyc_hi + 1;
            if (k == 8) host_req = 1'b0;
        end
        chk("hold_req pulses", pulses, 3);
        chk("hold_req cyc_cycles", cyc_hi, 3);
        chk("hold_req ready", 32'(host_ready), 32'd1);
        chk("hold_req rdata", host_rdat, 32'h00000077);

        // Asynchronous reset in the middle of a silent-slave attempt.
        @(negedge clk);
        cfg_stall = 0; cfg_resp = 0; cfg_rty = 0; cfg_fin = 0;
        host_we = 1'b0; host_adr = 3'b010; host_sel = 4'hF;
        host_req = 1'b1;
        @(negedge clk);
        host_req = 1'b0;
        chk("rst_mid cyc_before", 32'(wb_cyc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid cyc_async", 32'(wb_cyc), 32'd0);
        chk("rst_mid stb_async", 32'(wb_stb), 32'd0);
        chk("rst_mid ready_async", 32'(host_ready), 32'd1);
        @(negedge clk);
        chk("rst_mid rdata_cleared", host_rdat, 32'd0);
        rst_n = 1'b1;
        pulses = 0; cyc_hi = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (host_ack || host_err) pulses = pulses + 1;
            if (wb_cyc) cyc_hi = cyc_hi + 1;
        end
        chk("rst_mid pulses", pulses, 0);
        chk("rst_mid cyc_after", cyc_hi, 0);
        chk("rst_mid ready_after", 32'(host_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
